// File: rtl/fast_to_slow_sender.sv
// Fast-domain sender: buffers M-bit words in a small FIFO and hands them to a slower
// domain one at a time with a 4-phase req/ack handshake; ack_in is resynchronised here.
module fast_to_slow_sender #(
  parameter int M           = 15,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_in,
  input  logic [M-1:0] data_in,
  input  logic         ack_in,
  output logic         req_out,
  output logic [M-1:0] data_out,
  output logic         full,
  output logic         busy,
  output logic         overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   req_q, req_d;
  logic [M-1:0]           data_q, data_d;
  logic [M-1:0]           fifo_mem [DEPTH];
  logic                   ack_s;
  logic                   push;
  logic                   pop;
  logic                   full_w;

  assign ack_s  = ack_sync_q[SYNC_STAGES-1];
  assign full_w = (count_q == CW'(DEPTH));
  // Words leave the FIFO only as a new handshake is launched.
  assign pop    = (state_q == IDLE) && (count_q != '0);
  assign push   = valid_in && !full_w;

  // State register and all other flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ack_sync_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      req_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      ack_sync_q <= ack_sync_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      req_q      <= req_d;
      data_q     <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= data_in;
    end
  end

  always_comb begin
    ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], ack_in};
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    count_d    = count_q + CW'(push) - CW'(pop);
    overflow_d = overflow_q || (valid_in && full_w);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (count_q != '0) state_d = REQ;
      REQ:     if (ack_s)         state_d = RELEASE;
      RELEASE: if (!ack_s)        state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // req_out is a flop so the slow side never sees a decode glitch.
  always_comb begin
    req_d  = (state_d == REQ);
    data_d = data_q;
    if (pop) begin
      data_d = fifo_mem[rd_ptr_q];
    end
  end

  assign req_out  = req_q;
  assign data_out = data_q;
  assign full     = full_w;
  assign busy     = (state_q != IDLE) || (count_q != '0);
  assign overflow = overflow_q;

endmodule
